// File: rtl/msg_uart_rx_pkg.sv
// Shared definitions for the message-link receiver: FSM state encodings and
// default frame constants (also used by the CPU-side transmitter).
package msg_uart_rx_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DEPTH        = 8;
  localparam int DEF_DATA_W       = 8;

endpackage

// File: rtl/msg_uart_rx_fifo.sv
// First-word fall-through receive FIFO. rd_data is a register so that it
// reads 0 after reset and keeps the last popped value once the FIFO drains.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise the byte is dropped and a one-cycle drop pulse is raised.
module msg_uart_rx_fifo
  import msg_uart_rx_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [CW-1:0]     count,
  output logic              drop
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_ptr_nxt;
  logic              pop;
  logic              push_ok;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign pop        = rd_en && !empty;
  assign push_ok    = push && (!full || pop);
  assign drop       = push && !push_ok;
  assign rd_ptr_nxt = rd_ptr + AW'(1);

  // Storage array; no reset needed since rd_data gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and the registered head word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr_nxt;

      if (push_ok && !pop)      count <= count + CW'(1);
      else if (pop && !push_ok) count <= count - CW'(1);

      if (pop) begin
        if (count > CW'(1)) rd_data <= mem[rd_ptr_nxt];
        else if (push_ok)   rd_data <= push_data;
      end else if (empty && push_ok) begin
        rd_data <= push_data;
      end
    end
  end

endmodule

// File: rtl/msg_uart_rx.sv
// 8N1 serial receiver for the CPU's outgoing message link. Received bytes
// are queued in a FWFT FIFO; framing errors and overruns are sticky.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  RX_IDLE  | line idle, waiting for a falling edge (start bit)
//  RX_START | half-bit wait, then confirm start bit (reject glitches)
//  RX_DATA  | sample DATA_W bits one bit-time apart, LSB first
//  RX_STOP  | sample stop bit: high pushes the byte, low flags frame_err
module msg_uart_rx
  import msg_uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int DATA_W       = DEF_DATA_W,
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_i,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [CW-1:0]     count,
  input  logic              err_clr,
  output logic              frame_err,
  output logic              overrun
);

  localparam int BW  = $clog2(CLKS_PER_BIT);
  localparam int BCW = $clog2(DATA_W);

  logic              sync1, sync2;
  logic              line_prev;
  logic [1:0]        rdy;
  logic              fall;
  rx_state_t         state;
  logic [BW-1:0]     baud_cnt;
  logic [BCW-1:0]    bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              push_q;
  logic              drop;

  // line_prev is held low until the synchroniser carries real line data, so
  // a line that is already low at reset release cannot look like a start bit.
  assign fall = line_prev && !sync2;

  // Two-flop synchroniser plus edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      rdy       <= 2'b00;
      line_prev <= 1'b0;
    end else begin
      sync1     <= rx_i;
      sync2     <= sync1;
      rdy       <= {rdy[0], 1'b1};
      line_prev <= sync2 && rdy[1];
    end
  end

  // Receive FSM with down-counting baud timer, bit counter and frame_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RX_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      push_q    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (err_clr) frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (fall) begin
            state    <= RX_START;
            baud_cnt <= BW'(CLKS_PER_BIT / 2 - 1);
            bit_cnt  <= '0;
          end
        end
        RX_START: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BW'(CLKS_PER_BIT - 1);
            state    <= sync2 ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
        RX_DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BW'(CLKS_PER_BIT - 1);
            shreg    <= {sync2, shreg[DATA_W-1:1]};
            bit_cnt  <= bit_cnt + BCW'(1);
            if (bit_cnt == BCW'(DATA_W - 1)) state <= RX_STOP;
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
        RX_STOP: begin
          if (baud_cnt == '0) begin
            state <= RX_IDLE;
            if (sync2) push_q    <= 1'b1;
            else       frame_err <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // Sticky overrun; a drop in the same cycle as err_clr keeps it set.
  always_ff @(posedge clk) begin
    if (rst)          overrun <= 1'b0;
    else if (drop)    overrun <= 1'b1;
    else if (err_clr) overrun <= 1'b0;
  end

  // shreg is stable for many cycles after STOP, so it feeds the push directly.
  msg_uart_rx_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (shreg),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .drop      (drop)
  );

endmodule

// File: tb/tb_msg_uart_rx.sv
// Directed bench for msg_uart_rx (CLKS_PER_BIT=16, DEPTH=8, 10 ns clock).
module tb_msg_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_i;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       err_clr;
  logic       frame_err;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  msg_uart_rx #(
    .CLKS_PER_BIT (16),
    .DEPTH        (8),
    .DATA_W       (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (rx_i),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .err_clr   (err_clr),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start bit driven 1 ns after edge P0; each bit lasts 16 cycles.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    @(posedge clk); #1 rx_i = 1'b0;
    repeat (16) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx_i = d[i];
      repeat (16) @(posedge clk);
    end
    #1 rx_i = stop_bit;
    repeat (16) @(posedge clk);
    #1 rx_i = 1'b1;
  endtask

  task automatic pop();
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
  endtask

  task automatic clr_err();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic drain(input string tag, input logic [7:0] first, input int n);
    logic [7:0] exp_b;
    for (int i = 0; i < n; i++) begin
      exp_b = first + 8'(i);
      @(negedge clk);
      check(tag, 32'(rd_data), 32'(exp_b));
      pop();
    end
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"},  32'(full),  32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_rdata"}, 32'(rd_data), 32'd0);
    check({tag, "_ferr"},  32'(frame_err), 32'd0);
    check({tag, "_ovr"},   32'(overrun), 32'd0);
  endtask

  int c0;
  int fall_dly;

  initial begin
    rst = 1'b1; rx_i = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    idle(3);
    #1 rst = 1'b0;
    check_reset_state("rst");
    idle(20);

    // 1: start sample at P11, data at P27+16k, stop sample at P155, so the
    // push lands at edge P156 and empty is first seen low 156 cycles after P0.
    fall_dly = -1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge clk); #1 c0 = cyc;
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (!empty) begin
            fall_dly = cyc - c0;
            break;
          end
        end
      end
    join
    check("t1_push_latency", 32'(fall_dly), 32'd156);
    @(negedge clk);
    check("t1_rdata", 32'(rd_data), 32'hA5);
    check("t1_count", 32'(count), 32'd1);
    check("t1_flags", 32'({frame_err, overrun}), 32'd0);
    pop();
    @(negedge clk);
    check("t1_empty_after_pop", 32'(empty), 32'd1);
    idle(10);

    // 2: nine back-to-back frames, ninth is lost.
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1);
    idle(4);
    @(negedge clk);
    check("t2_full", 32'(full), 32'd1);
    check("t2_count", 32'(count), 32'd8);
    check("t2_overrun", 32'(overrun), 32'd1);
    check("t2_ferr", 32'(frame_err), 32'd0);
    drain("t2_drain", 8'h00, 8);
    @(negedge clk);
    check("t2_empty", 32'(empty), 32'd1);
    check("t2_rdata_hold", 32'(rd_data), 32'h07);
    clr_err();
    @(negedge clk);
    check("t2_ovr_clr", 32'(overrun), 32'd0);
    idle(10);

    // 3: bad stop bit.
    send_frame(8'h3C, 1'b0);
    idle(4);
    @(negedge clk);
    check("t3_ferr", 32'(frame_err), 32'd1);
    check("t3_count", 32'(count), 32'd0);
    check("t3_empty", 32'(empty), 32'd1);
    clr_err();
    @(negedge clk);
    check("t3_ferr_clr", 32'(frame_err), 32'd0);
    idle(20);

    // 4: glitch rejection, then a good frame.
    @(posedge clk); #1 rx_i = 1'b0;
    repeat (4) @(posedge clk); #1 rx_i = 1'b1;
    idle(40);
    @(negedge clk);
    check("t4_glitch_empty", 32'(empty), 32'd1);
    check("t4_glitch_flags", 32'({frame_err, overrun}), 32'd0);
    send_frame(8'h5A, 1'b1);
    idle(4);
    @(negedge clk);
    check("t4_rdata", 32'(rd_data), 32'h5A);
    check("t4_count", 32'(count), 32'd1);
    pop();
    idle(10);

    // 5: full FIFO, pop in the push cycle (edge P156) of frame 0x77.
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1);
    idle(4);
    @(negedge clk);
    check("t5_count_full", 32'(count), 32'd8);
    fork
      send_frame(8'h77, 1'b1);
      begin
        @(posedge clk);
        repeat (155) @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
      end
    join
    idle(4);
    @(negedge clk);
    check("t5_overrun", 32'(overrun), 32'd0);
    check("t5_count", 32'(count), 32'd8);
    drain("t5_drain", 8'h11, 7);
    @(negedge clk);
    check("t5_tail", 32'(rd_data), 32'h77);
    pop();
    idle(10);

    // 6: rst during DATA of 0xFF, with a queued byte and frame_err pending.
    send_frame(8'h44, 1'b1);
    send_frame(8'h3C, 1'b0);
    idle(20);
    @(negedge clk);
    check("t6_pre_count", 32'(count), 32'd1);
    check("t6_pre_ferr", 32'(frame_err), 32'd1);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        @(posedge clk);
        repeat (60) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    check_reset_state("t6_rst");
    idle(10);
    send_frame(8'h12, 1'b1);
    idle(4);
    @(negedge clk);
    check("t6_rdata", 32'(rd_data), 32'h12);
    check("t6_count", 32'(count), 32'd1);
    idle(10);

    // 7: line held low across reset release must not start a frame.
    @(posedge clk); #1 rx_i = 1'b0; rst = 1'b1;
    idle(3);
    #1 rst = 1'b0;
    idle(200);
    @(negedge clk);
    check("t7_low_empty", 32'(empty), 32'd1);
    check("t7_low_ferr", 32'(frame_err), 32'd0);
    #1 rx_i = 1'b1;
    idle(200);
    @(negedge clk);
    check("t7_high_empty", 32'(empty), 32'd1);
    check("t7_high_ferr", 32'(frame_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
